// File: rtl/bram2_pair_fetch_ctrl_pkg.sv
// rtl/bram2_pair_fetch_ctrl_pkg.sv - shared FSM encoding and read-latency limits
package bram2_pair_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WAIT = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/bram2_pair_fetch_ctrl_if.sv
// rtl/bram2_pair_fetch_ctrl_if.sv - request, BRAM2 read and response bundle
interface bram2_pair_fetch_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);

    logic              req0_valid;
    logic [3:0]        req0_fg_addr;
    logic              req0_ready;
    logic              req1_valid;
    logic [3:0]        req1_fg_addr;
    logic              req1_ready;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;

    modport slave (
        input  req0_valid, req0_fg_addr, req1_valid, req1_fg_addr,
        input  bram_dout, rsp_ready,
        output req0_ready, req1_ready, bram_en, bram_addr,
        output rsp_valid, rsp_id, rsp_data_a, rsp_data_b
    );

    modport master (
        output req0_valid, req0_fg_addr, req1_valid, req1_fg_addr,
        output bram_dout, rsp_ready,
        input  req0_ready, req1_ready, bram_en, bram_addr,
        input  rsp_valid, rsp_id, rsp_data_a, rsp_data_b
    );

endinterface

// File: rtl/bram2_pair_fetch_ctrl_fine_grain_map.sv
// rtl/bram2_pair_fetch_ctrl_fine_grain_map.sv - fine-grain address to BRAM2 pair map
module bram2_pair_fetch_ctrl_fine_grain_map (
    input  logic [3:0] fg_addr,
    output logic [3:0] addr_a,
    output logic [3:0] addr_b
);

    // Index 8 and index F sit alone; every other value pairs up.
    always_comb begin
        addr_a = 4'd0;
        case (fg_addr)
            4'h0, 4'h1: addr_a = 4'd0;
            4'h2, 4'h3: addr_a = 4'd1;
            4'h4, 4'h5: addr_a = 4'd2;
            4'h6, 4'h7: addr_a = 4'd3;
            4'h8:       addr_a = 4'd4;
            4'h9, 4'hA: addr_a = 4'd5;
            4'hB, 4'hC: addr_a = 4'd6;
            4'hD, 4'hE: addr_a = 4'd7;
            4'hF:       addr_a = 4'd8;
            default:    addr_a = 4'd0;
        endcase
    end

    assign addr_b = addr_a + 4'd1;

endmodule

// File: rtl/bram2_pair_fetch_ctrl.sv
// rtl/bram2_pair_fetch_ctrl.sv - round-robin pair fetch sequencer for BRAM2
module bram2_pair_fetch_ctrl
    import bram2_pair_fetch_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bram2_pair_fetch_ctrl_if.slave  bus
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("bram2_pair_fetch_ctrl: RD_LAT out of range");
    end

    state_t            state;
    logic              last_gnt;
    logic [3:0]        fg_q;
    logic              id_q;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              rsp_valid_q;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_b;

    logic              gnt_id;
    logic              idle;
    logic              accept;
    logic [3:0]        addr_a;
    logic [3:0]        addr_b;
    logic              issue;
    logic              tag_out_v;
    logic              tag_out_b;

    bram2_pair_fetch_ctrl_fine_grain_map u_map (
        .fg_addr (fg_q),
        .addr_a  (addr_a),
        .addr_b  (addr_b)
    );

    // On contention, grant whoever did not win last; a lone requester always wins.
    assign gnt_id = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;
    assign idle   = (state == ST_IDLE);
    assign accept = idle && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = idle && bus.req0_valid && !gnt_id;
    assign bus.req1_ready = idle && bus.req1_valid &&  gnt_id;

    always_comb begin
        bus.bram_en   = 1'b0;
        bus.bram_addr = '0;
        if (state == ST_RD_A) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = ADDR_W'(addr_a);
        end else if (state == ST_RD_B) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = ADDR_W'(addr_b);
        end
    end

    // Tags ride alongside the BRAM pipeline so only our own reads are captured.
    assign issue     = (state == ST_RD_A) || (state == ST_RD_B);
    assign tag_out_v = tag_v[RD_LAT-1];
    assign tag_out_b = tag_b[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_b <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_b[0] <= (state == ST_RD_B);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_gnt    <= 1'b1;
            fg_q        <= '0;
            id_q        <= 1'b0;
            data_a      <= '0;
            data_b      <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (tag_out_v) begin
                if (tag_out_b) begin
                    data_b <= bus.bram_dout;
                end else begin
                    data_a <= bus.bram_dout;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fg_q     <= gnt_id ? bus.req1_fg_addr : bus.req0_fg_addr;
                        id_q     <= gnt_id;
                        last_gnt <= gnt_id;
                        state    <= ST_RD_A;
                    end
                end
                ST_RD_A: state <= ST_RD_B;
                ST_RD_B: state <= ST_WAIT;
                ST_WAIT: begin
                    if (tag_out_v && tag_out_b) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data_a = data_a;
    assign bus.rsp_data_b = data_b;

endmodule
